// File: rtl/bus_reg_bank.sv
// bus_reg_bank: NREG bus-writable registers sitting as a slave on a shared
// tri-state data bus. Writes are sampled from the bus in IDLE; reads drive the
// bus from a registered copy of the selected register, and every read burst
// is followed by one undriven turnaround cycle. Protocol violations set a
// sticky error flag that only reset clears.
module bus_reg_bank #(
  parameter int              DW        = 32,
  parameter int              RW        = 16,
  parameter int              NREG      = 4,
  parameter int              AW        = 2,
  parameter logic [RW-1:0]   RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  inout  wire  [DW-1:0] ad,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          read_n,
  input  logic          write,
  output logic          drive_en,
  output logic [7:0]    wr_count,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t                   state_reg;
  logic [RW-1:0]            rdata_reg;
  logic [NREG-1:0][RW-1:0]  reg_q;

  logic addr_ok;
  logic wr_req;
  logic rd_req;
  logic wr_accept;

  // Upper bus bits carry nothing for this block.
  wire unused_ad_hi = ^ad[DW-1:RW];

  // Address range check is done one bit wider so NREG == 2**AW still works.
  assign addr_ok   = ({1'b0, addr} < (AW+1)'(NREG));
  assign wr_req    = cs & write;
  assign rd_req    = cs & ~read_n;
  assign wr_accept = (state_reg == IDLE) & wr_req & addr_ok;

  // The bus is only ever driven from flops, never from the inputs directly.
  assign ad = drive_en ? DW'(rdata_reg) : {DW{1'bz}};

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [RW-1:0] q_reg;

      // One storage register per address, loaded from the bus on an accepted write.
      always_ff @(posedge clk) begin
        if (reset) begin
          q_reg <= RESET_VAL;
        end else if (wr_accept && (addr == AW'(gi))) begin
          q_reg <= ad[RW-1:0];
        end
      end

      assign reg_q[gi] = q_reg;
    end
  endgenerate

  // Bus protocol FSM with registered drive enable, read data, write count and error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      drive_en  <= 1'b0;
      rdata_reg <= RESET_VAL;
      wr_count  <= 8'd0;
      err       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (wr_req) begin
            // A write always wins in IDLE; a concurrent read is a protocol error.
            if (addr_ok) begin
              wr_count <= wr_count + 8'd1;
            end else begin
              err <= 1'b1;
            end
            if (rd_req) begin
              err <= 1'b1;
            end
          end else if (rd_req) begin
            if (addr_ok) begin
              rdata_reg <= reg_q[addr];
              state_reg <= DRIVE;
              drive_en  <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end

        DRIVE: begin
          if (wr_req) begin
            err <= 1'b1;
          end
          if (rd_req) begin
            if (addr_ok) begin
              rdata_reg <= reg_q[addr];
            end else begin
              err <= 1'b1;
            end
          end else begin
            state_reg <= TURN;
            drive_en  <= 1'b0;
          end
        end

        TURN: begin
          if (wr_req) begin
            err <= 1'b1;
          end
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          drive_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_reg_bank.sv
// Directed testbench for bus_reg_bank: an external tri-state driver shares
// the bus with the DUT; a second instance with a wider address checks
// out-of-range handling.
module tb_bus_reg_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [2:0]  addr3;
  logic        cs, read_n, write;
  logic        ext_en, ext3_en;
  logic [31:0] ext_data, ext3_data;
  wire  [31:0] ad, ad3;
  logic        drive_en, err, drive_en3, err3;
  logic [7:0]  wr_count, wr_count3;

  int n_vec = 0;
  int n_bad = 0;

  assign ad  = ext_en  ? ext_data  : 32'hzzzz_zzzz;
  assign ad3 = ext3_en ? ext3_data : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  bus_reg_bank #(.DW(32), .RW(16), .NREG(4), .AW(2), .RESET_VAL(16'h0000)) u_dut (
    .clk(clk), .reset(reset), .ad(ad), .addr(addr), .cs(cs), .read_n(read_n),
    .write(write), .drive_en(drive_en), .wr_count(wr_count), .err(err)
  );

  bus_reg_bank #(.DW(32), .RW(16), .NREG(4), .AW(3), .RESET_VAL(16'h0000)) u_dut3 (
    .clk(clk), .reset(reset), .ad(ad3), .addr(addr3), .cs(cs), .read_n(read_n),
    .write(write), .drive_en(drive_en3), .wr_count(wr_count3), .err(err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    cs = 1'b0; read_n = 1'b1; write = 1'b0; ext_en = 1'b0; ext3_en = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; read_n = 1'b1; addr = a; ext_en = 1'b1; ext_data = d;
    tick();
    idle_bus();
  endtask

  // Read one register: first driven cycle, then end the read and pass TURN.
  task automatic do_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    cs = 1'b1; read_n = 1'b0; write = 1'b0; addr = a; ext_en = 1'b0;
    tick();
    chk({tag, "_den"}, 32'(drive_en), 32'd1);
    chk({tag, "_ad"}, ad, exp);
    idle_bus();
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; addr = '0; addr3 = '0; ext_data = '0; ext3_data = '0;
    idle_bus();
    tick();
    tick();
    chk("rst_den", 32'(drive_en), 32'd0);
    chk("rst_cnt", 32'(wr_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    tick();

    // Write via external driver, then read back with 1-cycle latency.
    do_write(2'd1, 32'haaaa_aaaa);
    cs = 1'b1; read_n = 1'b0; addr = 2'd1;
    tick();
    chk("rd1_den", 32'(drive_en), 32'd1);
    chk("rd1_ad", ad, 32'h0000_aaaa);
    chk("rd1_cnt", 32'(wr_count), 32'd1);
    chk("rd1_err", 32'(err), 32'd0);

    // End read: TURN lasts one cycle even with a new read pending.
    read_n = 1'b1;
    tick();
    chk("turn_den", 32'(drive_en), 32'd0);
    read_n = 1'b0;
    tick();
    chk("turn_idle_den", 32'(drive_en), 32'd0);
    tick();
    chk("reread_den", 32'(drive_en), 32'd1);
    chk("reread_ad", ad, 32'h0000_aaaa);
    idle_bus();
    tick();
    tick();
    tick();
    chk("idle_den", 32'(drive_en), 32'd0);

    // Fill all four registers; upper bus bits must be ignored.
    do_write(2'd0, 32'hffff_1111);
    do_write(2'd1, 32'h0000_2222);
    do_write(2'd2, 32'h1234_3333);
    do_write(2'd3, 32'h0000_4444);
    chk("fill_cnt", 32'(wr_count), 32'd5);

    // Streaming read: each address shows up one cycle after it is presented.
    cs = 1'b1; read_n = 1'b0; addr = 2'd0;
    tick();
    chk("str0", ad, 32'h0000_1111);
    addr = 2'd1;
    tick();
    chk("str1", ad, 32'h0000_2222);
    addr = 2'd2;
    tick();
    chk("str2", ad, 32'h0000_3333);
    addr = 2'd3;
    tick();
    chk("str3", ad, 32'h0000_4444);
    chk("str_err", 32'(err), 32'd0);

    // Write strobe while driving is ignored and flags an error.
    addr = 2'd0; write = 1'b1;
    tick();
    chk("drvwr_err", 32'(err), 32'd1);
    chk("drvwr_cnt", 32'(wr_count), 32'd5);
    chk("drvwr_ad", ad, 32'h0000_1111);
    write = 1'b0;
    idle_bus();
    tick();
    tick();
    do_read("drvwr_keep", 2'd0, 32'h0000_1111);

    // Reset clears error, count and registers.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_err", 32'(err), 32'd0);
    chk("rst2_cnt", 32'(wr_count), 32'd0);
    do_read("rst2_reg3", 2'd3, 32'h0000_0000);

    // Simultaneous write and read in IDLE: write wins, no read, error.
    cs = 1'b1; write = 1'b1; read_n = 1'b0; addr = 2'd2; ext_en = 1'b1; ext_data = 32'h0000_5a5a;
    tick();
    chk("wrrd_den", 32'(drive_en), 32'd0);
    chk("wrrd_err", 32'(err), 32'd1);
    chk("wrrd_cnt", 32'(wr_count), 32'd1);
    idle_bus();
    tick();
    do_read("wrrd_reg2", 2'd2, 32'h0000_5a5a);

    // Reset while driving releases the bus and clears registers.
    cs = 1'b1; read_n = 1'b0; addr = 2'd2;
    tick();
    chk("mid_den", 32'(drive_en), 32'd1);
    reset = 1'b1;
    tick();
    chk("midrst_den", 32'(drive_en), 32'd0);
    reset = 1'b0;
    idle_bus();
    tick();
    do_read("midrst_reg2", 2'd2, 32'h0000_0000);

    // Write counter wraps after 256 accepted writes.
    cs = 1'b1; write = 1'b1; read_n = 1'b1; addr = 2'd0; ext_en = 1'b1;
    for (int i = 0; i < 255; i++) begin
      ext_data = 32'(i);
      tick();
    end
    chk("cnt255", 32'(wr_count), 32'd255);
    tick();
    chk("cnt_wrap", 32'(wr_count), 32'd0);
    chk("cnt_err", 32'(err), 32'd0);
    idle_bus();
    tick();

    // Wide-address instance: valid write, then out-of-range write and read.
    cs = 1'b1; write = 1'b1; addr3 = 3'd3; ext3_en = 1'b1; ext3_data = 32'h0000_0bee;
    tick();
    chk("aw3_cnt1", 32'(wr_count3), 32'd1);
    chk("aw3_err0", 32'(err3), 32'd0);
    addr3 = 3'd5; ext3_data = 32'h0000_dead;
    tick();
    chk("aw3_bad_cnt", 32'(wr_count3), 32'd1);
    chk("aw3_bad_err", 32'(err3), 32'd1);
    write = 1'b0; ext3_en = 1'b0; read_n = 1'b0; addr3 = 3'd7;
    tick();
    chk("aw3_badrd_den", 32'(drive_en3), 32'd0);
    addr3 = 3'd3;
    tick();
    chk("aw3_rd_den", 32'(drive_en3), 32'd1);
    chk("aw3_rd_ad", ad3, 32'h0000_0bee);
    idle_bus();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
